// File: rtl/mouse_pkg.sv
// ---------------------------------------------------------------------------
// mouse_pkg
// Shared definitions for the PS/2 mouse packet decoder:
//   - decoder FSM state encoding
//   - bit positions inside packet byte 0 (buttons, sync, signs, overflows)
//   - compact header struct holding the byte-0 fields kept across a packet
//   - axis_delta(): builds, scales and overflow-clamps one 9-bit delta
// ---------------------------------------------------------------------------
package mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        GOT_B0  = 2'd1,
        GOT_B1  = 2'd2
    } mouse_state_t;

    // Byte 0 layout: {YO, XO, YS, XS, SYNC, BTN[2:0]}
    localparam int BTN_LSB  = 0;
    localparam int BTN_MSB  = 2;
    localparam int SYNC_BIT = 3;
    localparam int XS_BIT   = 4;
    localparam int YS_BIT   = 5;
    localparam int XO_BIT   = 6;
    localparam int YO_BIT   = 7;

    // Byte-0 fields that matter once the sync bit has been checked.
    typedef struct packed {
        logic       yo;
        logic       xo;
        logic       ys;
        logic       xs;
        logic [2:0] btn;
    } hdr_t;

    // 9-bit two's complement delta {sign, data}, arithmetically shifted right
    // by 'shift'. An overflowed axis reports zero movement with a clear sign.
    function automatic logic [8:0] axis_delta(
        input logic       sign,
        input logic [7:0] data,
        input logic       ovf,
        input int         shift
    );
        logic signed [8:0] v;
        v = $signed({sign, data});
        v = v >>> shift;
        if (ovf) begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/mouse_packet_decoder.sv
// ---------------------------------------------------------------------------
// mouse_packet_decoder
// Assembles 3-byte PS/2 mouse movement packets from the receiver byte stream
// and presents per-packet X/Y deltas for the game engine. Deltas and sign
// flags are nonzero for exactly one cycle per packet (the engine integrates
// them every cycle). Lost/garbled bytes are handled by checking the byte-0
// sync bit and by an inter-byte timeout that drops partial packets.
//
// Parameters
//   TIMEOUT_CYCLES  max clk cycles between bytes of one packet (>= 2)
//   DELTA_SHIFT     arithmetic right shift on each 9-bit delta (0..7)
//
// Ports
//   clk                in   system clock
//   arst_n             in   asynchronous active-low reset
//   i_byte[7:0]        in   received PS/2 data byte
//   i_byte_valid       in   1-cycle strobe, i_byte valid
//   o_mouse_dx[7:0]    out  X delta low 8 bits (0 unless o_packet_valid)
//   o_mouse_dy[7:0]    out  Y delta low 8 bits (0 unless o_packet_valid)
//   o_is_mouse_dx_neg  out  X delta bit 8 (0 unless o_packet_valid)
//   o_is_mouse_dy_neg  out  Y delta bit 8 (0 unless o_packet_valid)
//   o_buttons[2:0]     out  {middle,right,left} of last good packet
//   o_packet_valid     out  1-cycle pulse, packet decoded
//   o_sync_error       out  1-cycle pulse, byte discarded or packet aborted
// ---------------------------------------------------------------------------
module mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DELTA_SHIFT    = 0
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic [7:0] o_mouse_dx,
    output logic [7:0] o_mouse_dy,
    output logic       o_is_mouse_dx_neg,
    output logic       o_is_mouse_dy_neg,
    output logic [2:0] o_buttons,
    output logic       o_packet_valid,
    output logic       o_sync_error
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    mouse_state_t     state_q, state_d;
    hdr_t             hdr_q, hdr_d;
    logic [7:0]       xbyte_q, xbyte_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       dx9_q, dx9_d;
    logic [8:0]       dy9_q, dy9_d;
    logic [2:0]       buttons_q, buttons_d;
    logic             valid_q, valid_d;
    logic             sync_err_q, sync_err_d;

    logic             timeout_hit;

    assign timeout_hit = (cnt_q == CNT_MAX);

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        xbyte_d    = xbyte_q;
        cnt_d      = cnt_q;
        buttons_d  = buttons_q;
        // Pulse-type outputs default to zero every cycle.
        dx9_d      = '0;
        dy9_d      = '0;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;

        case (state_q)
            WAIT_B0: begin
                cnt_d = '0;
                if (i_byte_valid) begin
                    if (i_byte[SYNC_BIT]) begin
                        hdr_d.btn = i_byte[BTN_MSB:BTN_LSB];
                        hdr_d.xs  = i_byte[XS_BIT];
                        hdr_d.ys  = i_byte[YS_BIT];
                        hdr_d.xo  = i_byte[XO_BIT];
                        hdr_d.yo  = i_byte[YO_BIT];
                        state_d   = GOT_B0;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end

            GOT_B0: begin
                // A byte on the timeout cycle takes priority over the abort.
                if (i_byte_valid) begin
                    xbyte_d = i_byte;
                    cnt_d   = '0;
                    state_d = GOT_B1;
                end else if (timeout_hit) begin
                    cnt_d      = '0;
                    sync_err_d = 1'b1;
                    state_d    = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            GOT_B1: begin
                if (i_byte_valid) begin
                    dx9_d     = axis_delta(hdr_q.xs, xbyte_q, hdr_q.xo, DELTA_SHIFT);
                    dy9_d     = axis_delta(hdr_q.ys, i_byte, hdr_q.yo, DELTA_SHIFT);
                    buttons_d = hdr_q.btn;
                    valid_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_B0;
                end else if (timeout_hit) begin
                    cnt_d      = '0;
                    sync_err_d = 1'b1;
                    state_d    = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = WAIT_B0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= WAIT_B0;
            hdr_q      <= '0;
            xbyte_q    <= '0;
            cnt_q      <= '0;
            dx9_q      <= '0;
            dy9_q      <= '0;
            buttons_q  <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            xbyte_q    <= xbyte_d;
            cnt_q      <= cnt_d;
            dx9_q      <= dx9_d;
            dy9_q      <= dy9_d;
            buttons_q  <= buttons_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign o_mouse_dx        = dx9_q[7:0];
    assign o_mouse_dy        = dy9_q[7:0];
    assign o_is_mouse_dx_neg = dx9_q[8];
    assign o_is_mouse_dy_neg = dy9_q[8];
    assign o_buttons         = buttons_q;
    assign o_packet_valid    = valid_q;
    assign o_sync_error      = sync_err_q;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// ---------------------------------------------------------------------------
// tb_mouse_packet_decoder
// Directed bench for mouse_packet_decoder. Two instances share the byte
// stream: dut0 with DELTA_SHIFT=0 and dut2 with DELTA_SHIFT=2, both with a
// short timeout. Each output set is packed into one observation vector
// {valid, sync_err, dx_neg, dx, dy_neg, dy, buttons} for comparison.
// ---------------------------------------------------------------------------
module tb_mouse_packet_decoder;

    localparam int T = 16;

    logic       clk;
    logic       arst_n;
    logic [7:0] i_byte;
    logic       i_byte_valid;

    logic [7:0] dx0, dy0, dx2, dy2;
    logic       dxn0, dyn0, dxn2, dyn2;
    logic [2:0] btn0, btn2;
    logic       pv0, se0, pv2, se2;

    logic [22:0] obs0, obs2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mouse_packet_decoder #(.TIMEOUT_CYCLES(T), .DELTA_SHIFT(0)) dut0 (
        .clk(clk), .arst_n(arst_n), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
        .o_mouse_dx(dx0), .o_mouse_dy(dy0),
        .o_is_mouse_dx_neg(dxn0), .o_is_mouse_dy_neg(dyn0),
        .o_buttons(btn0), .o_packet_valid(pv0), .o_sync_error(se0)
    );

    mouse_packet_decoder #(.TIMEOUT_CYCLES(T), .DELTA_SHIFT(2)) dut2 (
        .clk(clk), .arst_n(arst_n), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
        .o_mouse_dx(dx2), .o_mouse_dy(dy2),
        .o_is_mouse_dx_neg(dxn2), .o_is_mouse_dy_neg(dyn2),
        .o_buttons(btn2), .o_packet_valid(pv2), .o_sync_error(se2)
    );

    assign obs0 = {pv0, se0, dxn0, dx0, dyn0, dy0, btn0};
    assign obs2 = {pv2, se2, dxn2, dx2, dyn2, dy2, btn2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        tick();
        i_byte_valid = 1'b0;
        i_byte       = 8'h00;
    endtask

    task automatic test_reset();
        logic [22:0] exp;
        exp = '0;
        arst_n       = 1'b0;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (obs0 !== exp) $display("FAIL reset_held dut0: got %h expected %h", obs0, exp);
        else pass_cnt++;
        arst_n = 1'b1;
        tick();
        total_cnt++;
        if (obs0 !== exp || obs2 !== exp)
            $display("FAIL reset_release: got %h/%h expected %h", obs0, obs2, exp);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [22:0] exp;
        send(8'h08);
        send(8'h05);
        exp = '0;
        total_cnt++;
        if (obs0 !== exp) $display("FAIL basic_partial: got %h expected %h", obs0, exp);
        else pass_cnt++;
        send(8'h03);
        exp = {1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 8'h03, 3'b000};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL basic_pkt: got %h expected %h", obs0, exp);
        else pass_cnt++;
        tick();
        exp = '0;
        total_cnt++;
        if (obs0 !== exp) $display("FAIL basic_after: got %h expected %h", obs0, exp);
        else pass_cnt++;
    endtask

    task automatic test_negative();
        logic [22:0] exp;
        send(8'h19);
        send(8'hFB);
        send(8'h00);
        exp = {1'b1, 1'b0, 1'b1, 8'hFB, 1'b0, 8'h00, 3'b001};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL neg_pkt dut0: got %h expected %h", obs0, exp);
        else pass_cnt++;
        // -5 >>> 2 = -2
        exp = {1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 3'b001};
        total_cnt++;
        if (obs2 !== exp) $display("FAIL neg_pkt dut2: got %h expected %h", obs2, exp);
        else pass_cnt++;
        tick();
        exp = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3'b001};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL neg_after_hold_btn: got %h expected %h", obs0, exp);
        else pass_cnt++;
    endtask

    task automatic test_shift();
        logic [22:0] exp;
        send(8'h18);
        send(8'hF0);
        send(8'h10);
        exp = {1'b1, 1'b0, 1'b1, 8'hFC, 1'b0, 8'h04, 3'b000};
        total_cnt++;
        if (obs2 !== exp) $display("FAIL shift2_pkt: got %h expected %h", obs2, exp);
        else pass_cnt++;
        exp = {1'b1, 1'b0, 1'b1, 8'hF0, 1'b0, 8'h10, 3'b000};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL shift0_pkt: got %h expected %h", obs0, exp);
        else pass_cnt++;
    endtask

    task automatic test_sync_error();
        logic [22:0] exp;
        send(8'h05);
        exp = {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL sync_discard: got %h expected %h", obs0, exp);
        else pass_cnt++;
        send(8'h08);
        send(8'h01);
        send(8'h01);
        exp = {1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 8'h01, 3'b000};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL sync_recover: got %h expected %h", obs0, exp);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [22:0] exp;
        send(8'h48);
        send(8'h7F);
        send(8'h04);
        exp = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 3'b000};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL xovf dut0: got %h expected %h", obs0, exp);
        else pass_cnt++;
        exp = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 3'b000};
        total_cnt++;
        if (obs2 !== exp) $display("FAIL xovf dut2: got %h expected %h", obs2, exp);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [22:0] exp;
        int err_seen;
        int err_at;
        int valid_seen;
        err_seen   = 0;
        err_at     = 0;
        valid_seen = 0;
        send(8'h08);
        send(8'h05);
        for (int i = 1; i <= T; i++) begin
            tick();
            if (se0) begin
                err_seen++;
                err_at = i;
            end
            if (pv0) valid_seen++;
        end
        total_cnt++;
        if (err_seen != 1 || err_at != T || valid_seen != 0)
            $display("FAIL timeout_abort: errors %0d at idle cycle %0d valids %0d, expected 1 at %0d valids 0",
                     err_seen, err_at, valid_seen, T);
        else pass_cnt++;
        send(8'h08);
        send(8'h02);
        send(8'h02);
        exp = {1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 8'h02, 3'b000};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL timeout_recover: got %h expected %h", obs0, exp);
        else pass_cnt++;
    endtask

    // Bytes arrive on the very last allowed cycle; they must be accepted.
    task automatic test_timeout_boundary();
        logic [22:0] exp;
        int err_seen;
        err_seen = 0;
        send(8'h08);
        for (int i = 0; i < T - 1; i++) begin
            tick();
            if (se0) err_seen++;
        end
        send(8'h05);
        for (int i = 0; i < T - 1; i++) begin
            tick();
            if (se0) err_seen++;
        end
        send(8'h06);
        exp = {1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 8'h06, 3'b000};
        total_cnt++;
        if (obs0 !== exp || err_seen != 0)
            $display("FAIL timeout_edge_byte: got %h errors %0d expected %h errors 0", obs0, err_seen, exp);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [22:0] exp;
        send(8'h08);
        send(8'h01);
        send(8'h02);
        exp = {1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 8'h02, 3'b000};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL b2b_pkt1: got %h expected %h", obs0, exp);
        else pass_cnt++;
        send(8'h28);
        exp = '0;
        total_cnt++;
        if (obs0 !== exp) $display("FAIL b2b_gap: got %h expected %h", obs0, exp);
        else pass_cnt++;
        send(8'h03);
        send(8'h04);
        exp = {1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 8'h04, 3'b000};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL b2b_pkt2 dut0: got %h expected %h", obs0, exp);
        else pass_cnt++;
        // Y9 = -252, >>> 2 = -63 = 9'h1C1; X = 3 >>> 2 = 0
        exp = {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC1, 3'b000};
        total_cnt++;
        if (obs2 !== exp) $display("FAIL b2b_pkt2 dut2: got %h expected %h", obs2, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_packet();
        logic [22:0] exp;
        int pulses;
        pulses = 0;
        send(8'h0F);
        send(8'h00);
        send(8'h00);
        exp = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3'b111};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL btn_all: got %h expected %h", obs0, exp);
        else pass_cnt++;
        send(8'h08);
        send(8'h05);
        #2 arst_n = 1'b0;
        #2 arst_n = 1'b1;
        exp = '0;
        total_cnt++;
        if (obs0 !== exp) $display("FAIL reset_async_clear: got %h expected %h", obs0, exp);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pv0 || se0) pulses++;
        end
        total_cnt++;
        if (pulses != 0) $display("FAIL reset_mid_no_pulse: got %0d pulses expected 0", pulses);
        else pass_cnt++;
        // Partial packet was dropped, so a non-sync byte is now rejected.
        send(8'h01);
        exp = {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000};
        total_cnt++;
        if (obs0 !== exp) $display("FAIL reset_mid_resync: got %h expected %h", obs0, exp);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_shift();
        test_sync_error();
        test_overflow();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
